// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and control-word constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        ERR      = 2'd3
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_r;
        logic idex_r;
        logic exmem_r;
        logic memwb_r;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_NORMAL    = 9'b11111_0000;
    localparam pipe_ctrl_t CTRL_FLUSH_ALL = 9'b00000_1111;
    localparam pipe_ctrl_t CTRL_HOLD      = 9'b00000_0000;
    localparam pipe_ctrl_t CTRL_MEM_STALL = 9'b00001_0001;
    localparam pipe_ctrl_t CTRL_REDIRECT  = 9'b11111_1100;
    localparam pipe_ctrl_t CTRL_LOAD_USE  = 9'b00111_0100;

    localparam int WAIT_W = 8;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare: EX load whose destination feeds a source read in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       MemRead_ex,
    input  logic [4:0] rdAddr_ex,
    input  logic [4:0] rs1Addr_id,
    input  logic [4:0] rs2Addr_id,
    input  logic       rs1Used_id,
    input  logic       rs2Used_id,
    output logic       load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = rs1Used_id && (rs1Addr_id == rdAddr_ex);
    assign rs2_hit  = rs2Used_id && (rs2Addr_id == rdAddr_ex);
    // x0 is hardwired zero, so a load into it never creates a dependency.
    assign load_use = MemRead_ex && (rdAddr_ex != 5'd0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with memory-timeout trap.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead_ex,
    input  logic [4:0]  rdAddr_ex,
    input  logic [4:0]  rs1Addr_id,
    input  logic [4:0]  rs2Addr_id,
    input  logic        rs1Used_id,
    input  logic        rs2Used_id,
    input  logic        Redirect_ex,
    input  logic        dmem_req,
    input  logic        dmem_ack,
    output logic        PC_en,
    output logic        IFID_en,
    output logic        IDEX_en,
    output logic        EXMEM_en,
    output logic        MEMWB_en,
    output logic        IFID_r,
    output logic        IDEX_r,
    output logic        EXMEM_r,
    output logic        MEMWB_r,
    output logic        trap,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              mem_stall;
    logic              load_use;
    logic              active;
    pipe_ctrl_t        ctrl;

    load_use_detect u_load_use_detect (
        .MemRead_ex (MemRead_ex),
        .rdAddr_ex  (rdAddr_ex),
        .rs1Addr_id (rs1Addr_id),
        .rs2Addr_id (rs2Addr_id),
        .rs1Used_id (rs1Used_id),
        .rs2Used_id (rs2Used_id),
        .load_use   (load_use)
    );

    assign mem_stall = dmem_req && !dmem_ack;
    assign active    = (state == RUN) || (state == MEM_WAIT);

    function automatic pipe_ctrl_t prio_ctrl(input logic ms, input logic redir, input logic lu);
        if (ms)         return CTRL_MEM_STALL;
        else if (redir) return CTRL_REDIRECT;
        else if (lu)    return CTRL_LOAD_USE;
        else            return CTRL_NORMAL;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= INIT;
        else        state <= next_state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               wait_cnt <= '0;
        else if (state == RUN && mem_stall)       wait_cnt <= '0;
        else if (state == MEM_WAIT && mem_stall)  wait_cnt <= wait_cnt + 1'b1;
    end

    always_comb begin
        next_state = state;
        ctrl       = CTRL_HOLD;
        case (state)
            INIT: begin
                ctrl       = CTRL_FLUSH_ALL;
                next_state = RUN;
            end
            RUN: begin
                ctrl = prio_ctrl(mem_stall, Redirect_ex, load_use);
                if (mem_stall) next_state = MEM_WAIT;
            end
            MEM_WAIT: begin
                // On the ack cycle the lower-priority terms already steer the pipeline.
                ctrl = prio_ctrl(mem_stall, Redirect_ex, load_use);
                if (!mem_stall)                   next_state = RUN;
                else if (wait_cnt == TIMEOUT_VAL) next_state = ERR;
            end
            ERR: begin
                ctrl = CTRL_HOLD;
            end
            default: begin
                ctrl       = CTRL_FLUSH_ALL;
                next_state = INIT;
            end
        endcase
    end

    assign PC_en    = ctrl.pc_en;
    assign IFID_en  = ctrl.ifid_en;
    assign IDEX_en  = ctrl.idex_en;
    assign EXMEM_en = ctrl.exmem_en;
    assign MEMWB_en = ctrl.memwb_en;
    assign IFID_r   = ctrl.ifid_r;
    assign IDEX_r   = ctrl.idex_r;
    assign EXMEM_r  = ctrl.exmem_r;
    assign MEMWB_r  = ctrl.memwb_r;
    assign trap     = (state == ERR);

`ifdef HAZARD_PERF_EN
    logic stall_inc;
    logic flush_inc;

    assign stall_inc = active && (mem_stall || (load_use && !Redirect_ex));
    assign flush_inc = active && Redirect_ex && !mem_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc) stall_cnt <= sat_inc(stall_cnt);
            if (flush_inc) flush_cnt <= sat_inc(flush_cnt);
        end
    end
`else
    logic unused_active;
    assign unused_active = active;
    assign stall_cnt     = '0;
    assign flush_cnt     = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table, corner sequences, random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int TMO = 4;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead_ex = 1'b0;
    logic [4:0]  rdAddr_ex = '0;
    logic [4:0]  rs1Addr_id = '0;
    logic [4:0]  rs2Addr_id = '0;
    logic        rs1Used_id = 1'b0;
    logic        rs2Used_id = 1'b0;
    logic        Redirect_ex = 1'b0;
    logic        dmem_req = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en;
    logic        IFID_r, IDEX_r, EXMEM_r, MEMWB_r;
    logic        trap;
    logic [31:0] stall_cnt, flush_cnt;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
        .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
        .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
        .Redirect_ex(Redirect_ex), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .PC_en(PC_en), .IFID_en(IFID_en), .IDEX_en(IDEX_en),
        .EXMEM_en(EXMEM_en), .MEMWB_en(MEMWB_en),
        .IFID_r(IFID_r), .IDEX_r(IDEX_r), .EXMEM_r(EXMEM_r), .MEMWB_r(MEMWB_r),
        .trap(trap), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Control word order: PC,IFID,IDEX,EXMEM,MEMWB enables then IFID,IDEX,EXMEM,MEMWB clears.
    localparam logic [8:0] W_INIT   = 9'b00000_1111;
    localparam logic [8:0] W_NORMAL = 9'b11111_0000;
    localparam logic [8:0] W_MEM    = 9'b00001_0001;
    localparam logic [8:0] W_REDIR  = 9'b11111_1100;
    localparam logic [8:0] W_LU     = 9'b00111_0100;
    localparam logic [8:0] W_ERR    = 9'b00000_0000;

    logic [8:0] dut_ctrl;
    assign dut_ctrl = {PC_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en, IFID_r, IDEX_r, EXMEM_r, MEMWB_r};

    int checks = 0;
    int passed = 0;

    // Reference model: 0 = post-reset flush cycle, 1 = running, 2 = trapped.
    int     m_phase = 0;
    int     m_streak = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    function automatic bit model_lu();
        return MemRead_ex && (rdAddr_ex != 5'd0) &&
               ((rs1Used_id && rs1Addr_id == rdAddr_ex) || (rs2Used_id && rs2Addr_id == rdAddr_ex));
    endfunction

    function automatic logic [8:0] model_ctrl();
        if (m_phase == 0) return W_INIT;
        if (m_phase == 2) return W_ERR;
        if (dmem_req && !dmem_ack) return W_MEM;
        if (Redirect_ex) return W_REDIR;
        if (model_lu()) return W_LU;
        return W_NORMAL;
    endfunction

    task automatic model_update();
        bit ms;
        ms = dmem_req && !dmem_ack;
        if (!rst_n) begin
            m_phase = 0; m_streak = 0; m_stall = 0; m_flush = 0;
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (ms || (model_lu() && !Redirect_ex)) m_stall++;
            if (Redirect_ex && !ms) m_flush++;
            if (ms) begin
                m_streak++;
                // Entry cycle plus MEM_TIMEOUT+1 counted wait cycles exhaust the budget.
                if (m_streak == TMO + 2) m_phase = 2;
            end else begin
                m_streak = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_ctrl"}, {23'b0, dut_ctrl}, {23'b0, model_ctrl()});
        check({tag, "_trap"}, {31'b0, trap}, {31'b0, (m_phase == 2)});
        check({tag, "_stall_cnt"}, stall_cnt, PERF ? 32'(m_stall) : 32'd0);
        check({tag, "_flush_cnt"}, flush_cnt, PERF ? 32'(m_flush) : 32'd0);
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        compare_all(tag);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        MemRead_ex = 0; rdAddr_ex = 0; rs1Addr_id = 0; rs2Addr_id = 0;
        rs1Used_id = 0; rs2Used_id = 0; Redirect_ex = 0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        m_phase = 0; m_streak = 0; m_stall = 0; m_flush = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic       mr;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, redir, req, ack;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[10];
    bit   prev_ms;

    initial begin
        vecs[0] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W_NORMAL};
        vecs[1] = '{1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W_LU};
        vecs[2] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, W_NORMAL};
        vecs[3] = '{1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, W_NORMAL};
        vecs[4] = '{1'b1, 5'd7, 5'd7, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, W_LU};
        vecs[5] = '{1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, W_REDIR};
        vecs[6] = '{1'b1, 5'd9, 5'd9, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, W_LU};
        vecs[7] = '{1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, W_MEM};
        vecs[8] = '{1'b0, 5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, W_REDIR};
        vecs[9] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, W_NORMAL};

        // Reset state, including the single post-release flush cycle.
        rst_n = 1'b0;
        clear_inputs();
        @(posedge clk); #1;
        check("reset_ctrl", {23'b0, dut_ctrl}, {23'b0, W_INIT});
        check("reset_trap", {31'b0, trap}, 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        check("reset_flush_cnt", flush_cnt, 32'd0);
        do_reset();
        @(negedge clk);
        check("post_release_ctrl", {23'b0, dut_ctrl}, {23'b0, W_INIT});
        @(posedge clk); model_update(); #1;
        cycle("first_run");
        check("first_run_normal", {23'b0, dut_ctrl}, {23'b0, W_NORMAL});

        // Vector table.
        foreach (vecs[i]) begin
            MemRead_ex = vecs[i].mr; rdAddr_ex = vecs[i].rd;
            rs1Addr_id = vecs[i].rs1; rs2Addr_id = vecs[i].rs2;
            rs1Used_id = vecs[i].u1; rs2Used_id = vecs[i].u2;
            Redirect_ex = vecs[i].redir; dmem_req = vecs[i].req; dmem_ack = vecs[i].ack;
            @(negedge clk);
            check($sformatf("vec%0d_table", i), {23'b0, dut_ctrl}, {23'b0, vecs[i].exp});
            compare_all($sformatf("vec%0d", i));
            @(posedge clk); model_update(); #1;
        end

        // Redirect masks a simultaneous load-use.
        do_reset();
        cycle("redir_init");
        MemRead_ex = 1; rdAddr_ex = 5; rs2Addr_id = 5; rs2Used_id = 1; Redirect_ex = 1;
        cycle("redir_lu");
        clear_inputs();
        @(negedge clk);
        check("redir_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
        check("redir_stall_cnt", stall_cnt, 32'd0);
        @(posedge clk); model_update(); #1;

        // Ack three cycles after the request rises.
        do_reset();
        cycle("mw_init");
        dmem_req = 1; dmem_ack = 0;
        repeat (3) cycle("mw_hold");
        dmem_ack = 1;
        @(negedge clk);
        check("mw_ack_ctrl", {23'b0, dut_ctrl}, {23'b0, W_NORMAL});
        @(posedge clk); model_update(); #1;
        clear_inputs();
        @(negedge clk);
        check("mw_stall_cnt", stall_cnt, PERF ? 32'd3 : 32'd0);
        @(posedge clk); model_update(); #1;

        // Hung handshake traps; ERR ignores inputs until reset.
        do_reset();
        cycle("tmo_init");
        dmem_req = 1; dmem_ack = 0;
        repeat (TMO + 2) cycle("tmo_wait");
        @(negedge clk);
        check("tmo_trap", {31'b0, trap}, 32'd1);
        check("tmo_frozen", {23'b0, dut_ctrl}, {23'b0, W_ERR});
        @(posedge clk); model_update(); #1;
        for (int k = 0; k < 3; k++) begin
            MemRead_ex = 1; rdAddr_ex = 3; rs1Addr_id = 3; rs1Used_id = 1;
            Redirect_ex = k[0]; dmem_ack = 1;
            cycle("err_hold");
        end
        rst_n = 1'b0; #1;
        check("tmo_reset_trap", {31'b0, trap}, 32'd0);
        check("tmo_reset_ctrl", {23'b0, dut_ctrl}, {23'b0, W_INIT});

        // Reset asserted in the middle of a memory wait takes effect without a clock.
        do_reset();
        cycle("mid_init");
        dmem_req = 1; dmem_ack = 0;
        cycle("mid_stall0");
        cycle("mid_stall1");
        #2 rst_n = 1'b0; #1;
        check("midrst_ctrl", {23'b0, dut_ctrl}, {23'b0, W_INIT});
        check("midrst_trap", {31'b0, trap}, 32'd0);

        // Random traffic against the model, with periodic resets.
        prev_ms = 0;
        for (int n = 0; n < 400; n++) begin
            if (n % 80 == 0) begin
                do_reset();
                prev_ms = 0;
            end
            MemRead_ex  = 1'($urandom_range(0, 1));
            rdAddr_ex   = 5'($urandom_range(0, 3));
            rs1Addr_id  = 5'($urandom_range(0, 3));
            rs2Addr_id  = 5'($urandom_range(0, 3));
            rs1Used_id  = 1'($urandom_range(0, 1));
            rs2Used_id  = 1'($urandom_range(0, 1));
            Redirect_ex = ($urandom_range(0, 3) == 0);
            if (prev_ms) begin
                dmem_req = 1;
                dmem_ack = ($urandom_range(0, 2) == 0);
            end else begin
                dmem_req = ($urandom_range(0, 2) == 0);
                dmem_ack = 1'($urandom_range(0, 1));
            end
            prev_ms = dmem_req && !dmem_ack;
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
